// File: rtl/maxpool2d_stream.sv
// 2x2 stride-2 signed max-pooling over a row-major, channel-after-channel pixel stream.
// One half-width line buffer holds horizontal maxima of even rows until the odd row arrives.
module maxpool2d_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_WIDTH  = 256,
    parameter int ADDR_WIDTH = 28
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [8:0]            i_width,
    input  logic [8:0]            i_height,
    input  logic [9:0]            i_channels,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int LB_DEPTH = MAX_WIDTH / 2;
    localparam int LB_AW    = $clog2(LB_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t                         state_q, state_d;
    logic [8:0]                     width_q, width_d;
    logic [8:0]                     height_q, height_d;
    logic [9:0]                     chans_q, chans_d;
    logic [8:0]                     col_q, col_d;
    logic [8:0]                     row_q, row_d;
    logic [9:0]                     ch_q, ch_d;
    logic signed [DATA_WIDTH-1:0]   h_q, h_d;
    logic [ADDR_WIDTH-1:0]          cnt_q, cnt_d;
    logic                           o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0]          o_data_q, o_data_d;
    logic [ADDR_WIDTH-1:0]          o_addr_q, o_addr_d;

    logic signed [DATA_WIDTH-1:0]   line_buf [LB_DEPTH];
    logic [LB_AW-1:0]               lb_idx;
    logic                           lb_we;
    logic signed [DATA_WIDTH-1:0]   pix, hmax, lb_rd, vmax;
    logic                           last_col, last_row, last_ch;

    assign pix      = signed'(i_data);
    assign lb_idx   = col_q[LB_AW:1];
    assign lb_rd    = line_buf[lb_idx];
    assign hmax     = (pix > h_q) ? pix : h_q;
    assign vmax     = (lb_rd > hmax) ? lb_rd : hmax;
    assign last_col = (col_q == width_q - 9'd1);
    assign last_row = (row_q == height_q - 9'd1);
    assign last_ch  = (ch_q == chans_q - 10'd1);

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        chans_d   = chans_q;
        col_d     = col_q;
        row_d     = row_q;
        ch_d      = ch_q;
        h_d       = h_q;
        cnt_d     = cnt_q;
        o_valid_d = 1'b0;
        o_data_d  = o_data_q;
        o_addr_d  = o_addr_q;
        lb_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    width_d  = i_width;
                    height_d = i_height;
                    chans_d  = i_channels;
                    col_d    = '0;
                    row_d    = '0;
                    ch_d     = '0;
                    cnt_d    = '0;
                    if (i_width == '0 || i_height == '0 || i_channels == '0)
                        state_d = S_FIN;
                    else
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (i_valid) begin
                    // Odd trailing column/row never reaches an odd-col/odd-row slot, so floor falls out naturally.
                    if (!col_q[0]) begin
                        h_d = pix;
                    end else if (!row_q[0]) begin
                        lb_we = 1'b1;
                    end else begin
                        o_valid_d = 1'b1;
                        o_data_d  = vmax;
                        o_addr_d  = cnt_q;
                        cnt_d     = cnt_q + 1'b1;
                    end

                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d = '0;
                            ch_d  = ch_q + 10'd1;
                            if (last_ch)
                                state_d = S_FIN;
                        end else begin
                            row_d = row_q + 9'd1;
                        end
                    end else begin
                        col_d = col_q + 9'd1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            width_q   <= '0;
            height_q  <= '0;
            chans_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            ch_q      <= '0;
            h_q       <= '0;
            cnt_q     <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_addr_q  <= '0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            height_q  <= height_d;
            chans_q   <= chans_d;
            col_q     <= col_d;
            row_q     <= row_d;
            ch_q      <= ch_d;
            h_q       <= h_d;
            cnt_q     <= cnt_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_addr_q  <= o_addr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (lb_we)
            line_buf[lb_idx] <= hmax;
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_addr  = o_addr_q;
    assign o_busy  = (state_q == S_RUN);
    assign o_done  = (state_q == S_FIN);

endmodule

// File: tb/tb_maxpool2d_stream.sv
// Scoreboard bench for maxpool2d_stream: expected pooled pixels are computed from whole frames
// with plain array arithmetic and popped by a monitor whenever o_valid is seen.
module tb_maxpool2d_stream;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [8:0]         width;
    logic [8:0]         height;
    logic [9:0]         channels;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic signed [15:0] out_data;
    logic [27:0]        out_addr;
    logic               busy;
    logic               done;

    typedef struct {
        logic [27:0]        addr;
        logic signed [15:0] data;
    } exp_t;

    exp_t               exp_q[$];
    logic signed [15:0] pix_q[$];
    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int done_exp = 0;

    always #5 clk = ~clk;

    maxpool2d_stream #(
        .DATA_WIDTH(16),
        .MAX_WIDTH (256),
        .ADDR_WIDTH(28)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_width   (width),
        .i_height  (height),
        .i_channels(channels),
        .i_valid   (in_valid),
        .i_data    (in_data),
        .o_valid   (out_valid),
        .o_data    (out_data),
        .o_addr    (out_addr),
        .o_busy    (busy),
        .o_done    (done)
    );

    task automatic chk(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) done_seen++;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_o_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("o_addr", longint'(out_addr), longint'(e.addr));
                chk("o_data", longint'(out_data), longint'(e.data));
            end
        end
    end

    function automatic logic signed [15:0] px(int w, int h, int ch, int r, int c);
        return pix_q[(ch * h + r) * w + c];
    endfunction

    // Reference: every 2x2 window fully inside the frame yields the max of its four pixels.
    task automatic build_expected(input int w, input int h, input int c);
        int a;
        logic signed [15:0] m, v;
        exp_t e;
        a = 0;
        for (int ch = 0; ch < c; ch++)
            for (int r = 0; r < h / 2; r++)
                for (int cc = 0; cc < w / 2; cc++) begin
                    m = px(w, h, ch, 2 * r, 2 * cc);
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++) begin
                            v = px(w, h, ch, 2 * r + dr, 2 * cc + dc);
                            if (v > m) m = v;
                        end
                    e.addr = 28'(a);
                    e.data = m;
                    exp_q.push_back(e);
                    a++;
                end
    endtask

    task automatic drive_start(input int w, input int h, input int c);
        @(posedge clk); #1;
        start    = 1'b1;
        width    = 9'(w);
        height   = 9'(h);
        channels = 10'(c);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic fill_random(input int n);
        pix_q.delete();
        for (int i = 0; i < n; i++) pix_q.push_back(16'($urandom));
    endtask

    task automatic fill_seq(input int n);
        pix_q.delete();
        for (int i = 0; i < n; i++) pix_q.push_back(16'(i));
    endtask

    // gap_mode: 0 back-to-back, 1 idle cycle before every pixel, 2 random idles.
    task automatic run_frame(input int w, input int h, input int c, input int gap_mode, input int restart_at);
        int n;
        n = w * h * c;
        build_expected(w, h, c);
        drive_start(w, h, c);
        if (n == 0) begin
            @(negedge clk);
            chk("zero_dim_done", done, 1);
            chk("zero_dim_busy", busy, 0);
            done_exp++;
            @(negedge clk);
            chk("zero_dim_done_width", done, 0);
            return;
        end
        chk("busy_in_run", busy, 1);
        for (int i = 0; i < n; i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = pix_q[i];
            if (i == restart_at) begin
                start    = 1'b1;
                width    = 9'd2;
                height   = 9'd2;
                channels = 10'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("done_with_last", done, 1);
        chk("busy_cleared", busy, 0);
        done_exp++;
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        chk("scoreboard_drained", longint'(exp_q.size()), 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stimulus
        int w, h, c;
        rst = 1'b1; start = 1'b0; width = '0; height = '0; channels = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_o_valid", out_valid, 0);
        chk("reset_o_addr", longint'(out_addr), 0);
        chk("reset_o_busy", busy, 0);
        chk("reset_o_done", done, 0);

        fill_seq(16);
        run_frame(4, 4, 1, 0, -1);

        pix_q.delete();
        pix_q = '{-16'sd8, -16'sd3, -16'sd1, -16'sd20, -16'sd5, -16'sd9, -16'sd2, -16'sd30};
        run_frame(4, 2, 1, 0, -1);

        fill_seq(15);
        run_frame(5, 3, 1, 0, -1);

        pix_q.delete();
        pix_q = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd9, 16'sd0, 16'sd0, 16'sd0,
                  -16'sd1, -16'sd1, -16'sd1, -16'sd1};
        run_frame(2, 2, 3, 1, -1);

        pix_q.delete();
        run_frame(0, 4, 1, 0, -1);
        run_frame(4, 0, 1, 0, -1);
        run_frame(4, 4, 0, 0, -1);

        fill_seq(16);
        run_frame(4, 4, 1, 0, 6);

        fill_random(3);
        run_frame(1, 3, 1, 2, -1);
        fill_random(4);
        run_frame(4, 1, 1, 0, -1);

        // Reset mid-frame: only the first pooled pixel (from pixel 5) is ever produced.
        fill_seq(16);
        build_expected(4, 4, 1);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        drive_start(4, 4, 1);
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = pix_q[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_o_valid", out_valid, 0);
        chk("midrst_o_data", longint'(out_data), 0);
        chk("midrst_o_addr", longint'(out_addr), 0);
        chk("midrst_o_busy", busy, 0);
        chk("midrst_o_done", done, 0);
        chk("midrst_drained", longint'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
        fill_seq(16);
        run_frame(4, 4, 1, 0, -1);

        for (int k = 0; k < 8; k++) begin
            w = $urandom_range(1, 9);
            h = $urandom_range(1, 7);
            c = $urandom_range(1, 3);
            fill_random(w * h * c);
            run_frame(w, h, c, 2, -1);
        end

        fill_random(256 * 2 * 2);
        run_frame(256, 2, 2, 0, -1);
        fill_random(255 * 3);
        run_frame(255, 3, 1, 2, -1);

        repeat (3) @(negedge clk);
        chk("done_pulse_count", done_seen, done_exp);
        chk("final_queue_empty", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
